square_motion_ctrl: RTL

Position controller for the square-overlay renderer. It accepts move commands from a host over a valid/ready handshake and clamps each target to the visible area. It sequences the square's outer x/y offset, applying changes only at the frame boundary so the renderer never tears mid-frame. Sits between the command source (touch/UART decoder) and the square renderer's offset inputs, sharing the renderer's raster counters.

---
 rtl/square_pkg.sv | 41 ++++
 rtl/axis_stepper.sv | 29 ++
 rtl/square_motion_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/square_pkg.sv
// Shared definitions for the square-overlay motion controller and renderer:
// controller state encoding, raster geometry and target clamping helpers.
package square_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        MOVE   = 2'd2,
        BOUNCE = 2'd3
    } state_t;

    // Raster geometry shared with the renderer
    localparam int X_LIM  = 1055;   // last horizontal raster count
    localparam int Y_LIM  = 524;    // last vertical raster count
    localparam int H_VIS  = 800;    // visible pixels per line
    localparam int V_VIS  = 480;    // visible lines per frame
    localparam int SQ_LEN = 100;    // outer square side length

    // Largest offsets that keep the whole square on screen
    localparam int X_MAX  = H_VIS - 1 - SQ_LEN;  // 699
    localparam int Y_MAX  = V_VIS - 1 - SQ_LEN;  // 379

    // Limit a requested x offset to the visible area
    function automatic logic [10:0] clamp_x(input logic [10:0] v);
        if (v > 11'(X_MAX)) begin
            return 11'(X_MAX);
        end else begin
            return v;
        end
    endfunction

    // Limit a requested y offset to the visible area
    function automatic logic [9:0] clamp_y(input logic [9:0] v);
        if (v > 10'(Y_MAX)) begin
            return 10'(Y_MAX);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/axis_stepper.sv
// One-axis glide step: moves cur toward tgt by at most step, never
// overshooting and never wrapping. at_tgt reports that next lands on tgt.
module axis_stepper #(
    parameter int W = 11
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    input  logic [W-1:0] step,
    output logic [W-1:0] next,
    output logic         at_tgt
);

    logic [W-1:0] w_diff;

    // Saturating step toward the target using unsigned native-width math
    always_comb begin
        w_diff = '0;
        next   = cur;
        if (cur < tgt) begin
            w_diff = tgt - cur;
            next   = (w_diff > step) ? (cur + step) : tgt;
        end else begin
            w_diff = cur - tgt;
            next   = (w_diff > step) ? (cur - step) : tgt;
        end
        at_tgt = (next == tgt);
    end

endmodule

// File: rtl/square_motion_ctrl.sv
// Square position controller: accepts move commands over valid/ready,
// clamps them to the visible area and changes the offsets only in the
// cycle after the last raster position, coincident with frame_tick.
// Optional build macro AUTO_BOUNCE_EN adds an idle-triggered bounce mode.
module square_motion_ctrl
    import square_pkg::*;
#(
    parameter int STEP   = 4,
    parameter int X_INIT = 100,
    parameter int Y_INIT = 100
`ifdef AUTO_BOUNCE_EN
    ,
    parameter int IDLE_FRAMES = 60
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Xpos,
    input  logic [9:0]  Ypos,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic        cmd_snap,
    output logic [10:0] x_offset,
    output logic [9:0]  y_offset,
    output logic        busy,
    output logic        frame_tick
);

    localparam logic [10:0] C_STEP_X = 11'(STEP);
    localparam logic [9:0]  C_STEP_Y = 10'(STEP);

    state_t      r_state;
    logic [10:0] r_tgt_x;
    logic [9:0]  r_tgt_y;
    logic        r_snap;

    logic        w_frame_end;
    logic        w_hs;
    logic [10:0] w_x_next;
    logic [9:0]  w_y_next;
    logic        w_x_at;
    logic        w_y_at;

    assign w_frame_end = (Xpos == 11'(X_LIM)) && (Ypos == 10'(Y_LIM));
    assign w_hs        = cmd_valid && cmd_ready;
    assign busy        = (r_state != IDLE);

`ifdef AUTO_BOUNCE_EN
    localparam int CW = $clog2(IDLE_FRAMES + 1);

    logic [CW-1:0] r_idle_cnt;
    logic          r_dir_x_neg;
    logic          r_dir_y_neg;
    logic [11:0]   w_x_up;
    logic [10:0]   w_y_up;
    logic [10:0]   w_bx_next;
    logic [9:0]    w_by_next;
    logic          w_bx_flip;
    logic          w_by_flip;

    assign cmd_ready = (r_state == IDLE) || (r_state == BOUNCE);

    // Bounce step per axis: reflect at 0 and at the clamp maximum
    always_comb begin
        w_x_up    = {1'b0, x_offset} + 12'(STEP);
        w_y_up    = {1'b0, y_offset} + 11'(STEP);
        w_bx_next = x_offset;
        w_by_next = y_offset;
        w_bx_flip = 1'b0;
        w_by_flip = 1'b0;
        if (!r_dir_x_neg) begin
            if (w_x_up > 12'(X_MAX)) begin
                w_bx_next = 11'(X_MAX);
                w_bx_flip = 1'b1;
            end else begin
                w_bx_next = w_x_up[10:0];
            end
        end else begin
            if (x_offset < C_STEP_X) begin
                w_bx_next = 11'd0;
                w_bx_flip = 1'b1;
            end else begin
                w_bx_next = x_offset - C_STEP_X;
            end
        end
        if (!r_dir_y_neg) begin
            if (w_y_up > 11'(Y_MAX)) begin
                w_by_next = 10'(Y_MAX);
                w_by_flip = 1'b1;
            end else begin
                w_by_next = w_y_up[9:0];
            end
        end else begin
            if (y_offset < C_STEP_Y) begin
                w_by_next = 10'd0;
                w_by_flip = 1'b1;
            end else begin
                w_by_next = y_offset - C_STEP_Y;
            end
        end
    end
`else
    assign cmd_ready = (r_state == IDLE);
`endif

    axis_stepper #(.W(11)) u_step_x (
        .cur    (x_offset),
        .tgt    (r_tgt_x),
        .step   (C_STEP_X),
        .next   (w_x_next),
        .at_tgt (w_x_at)
    );

    axis_stepper #(.W(10)) u_step_y (
        .cur    (y_offset),
        .tgt    (r_tgt_y),
        .step   (C_STEP_Y),
        .next   (w_y_next),
        .at_tgt (w_y_at)
    );

    // Controller FSM with registered offsets and frame tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_tgt_x    <= 11'd0;
            r_tgt_y    <= 10'd0;
            r_snap     <= 1'b0;
            x_offset   <= 11'(X_INIT);
            y_offset   <= 10'(Y_INIT);
            frame_tick <= 1'b0;
`ifdef AUTO_BOUNCE_EN
            r_idle_cnt  <= '0;
            r_dir_x_neg <= 1'b0;
            r_dir_y_neg <= 1'b0;
`endif
        end else begin
            frame_tick <= w_frame_end;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_tgt_x <= clamp_x(cmd_x);
                        r_tgt_y <= clamp_y(cmd_y);
                        r_snap  <= cmd_snap;
                        r_state <= PEND;
`ifdef AUTO_BOUNCE_EN
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == CW'(IDLE_FRAMES)) begin
                        r_state <= BOUNCE;
                    end else if (w_frame_end) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
`endif
                    end
                end
                PEND: begin
`ifdef AUTO_BOUNCE_EN
                    r_idle_cnt <= '0;
`endif
                    if (w_frame_end) begin
                        if (r_snap) begin
                            x_offset <= r_tgt_x;
                            y_offset <= r_tgt_y;
                            r_state  <= IDLE;
                        end else begin
                            x_offset <= w_x_next;
                            y_offset <= w_y_next;
                            r_state  <= (w_x_at && w_y_at) ? IDLE : MOVE;
                        end
                    end
                end
                MOVE: begin
`ifdef AUTO_BOUNCE_EN
                    r_idle_cnt <= '0;
`endif
                    if (w_frame_end) begin
                        x_offset <= w_x_next;
                        y_offset <= w_y_next;
                        if (w_x_at && w_y_at) begin
                            r_state <= IDLE;
                        end
                    end
                end
`ifdef AUTO_BOUNCE_EN
                BOUNCE: begin
                    if (w_hs) begin
                        r_tgt_x    <= clamp_x(cmd_x);
                        r_tgt_y    <= clamp_y(cmd_y);
                        r_snap     <= cmd_snap;
                        r_state    <= PEND;
                        r_idle_cnt <= '0;
                    end else if (w_frame_end) begin
                        x_offset <= w_bx_next;
                        y_offset <= w_by_next;
                        if (w_bx_flip) begin
                            r_dir_x_neg <= ~r_dir_x_neg;
                        end
                        if (w_by_flip) begin
                            r_dir_y_neg <= ~r_dir_y_neg;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
